// File: rtl/lfsr_galois_if.sv
// Purpose : bus bundle for the Galois LFSR (control strobes, seed/tap inputs, state output).
// Latency : n/a (wires only); the LFSR registers DATA_O one clock after a sampled strobe.
// Backpr. : none; the LFSR accepts a load or a step on every clock.
//
// Signals:
//   EN_I    shift enable, one Galois step per clock while high
//   LOAD_I  load strobe, captures SEED_I and POLY_I
//   SEED_I  initial state captured on load (zero is replaced by all-ones)
//   POLY_I  tap mask captured on load; bit i set = feedback XOR into state bit i
//   DATA_O  current LFSR state, straight from the state register
interface lfsr_galois_if #(
  parameter int MAX_LEN = 8
);
  logic               EN_I;
  logic               LOAD_I;
  logic [MAX_LEN-1:0] SEED_I;
  logic [MAX_LEN-1:0] POLY_I;
  logic [MAX_LEN-1:0] DATA_O;

  // Driver side (stimulus / upstream control).
  modport master (
    output EN_I,
    output LOAD_I,
    output SEED_I,
    output POLY_I,
    input  DATA_O
  );

  // LFSR side.
  modport slave (
    input  EN_I,
    input  LOAD_I,
    input  SEED_I,
    input  POLY_I,
    output DATA_O
  );
endinterface

// File: rtl/lfsr_galois.sv
// Purpose : right-shifting Galois LFSR with a run-time loadable seed and tap mask.
// Latency : one clock; a load or step sampled on a rising edge is visible on DATA_O after it.
// Backpr. : none; every clock is either reset, load, step or hold (in that priority).
//
// Ports:
//   CLK_I        single clock, all state changes on its rising edge
//   RST_I        synchronous active-high reset: state <= all-ones, taps <= RST_POLY
//   bus (slave)  EN_I / LOAD_I / SEED_I / POLY_I in, DATA_O out (see lfsr_galois_if)
module lfsr_galois #(
  parameter int                 MAX_LEN  = 8,
  parameter logic [MAX_LEN-1:0] RST_POLY = MAX_LEN'(8'hB8)
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  lfsr_galois_if.slave bus
);

  // Widths below 2 leave no room for a shift-plus-feedback step; the upper
  // bound keeps the block within the range it is characterised for.
  if (MAX_LEN < 2 || MAX_LEN > 64) begin : g_bad_max_len
    $error("lfsr_galois: MAX_LEN must be in 2..64");
  end

  localparam logic [MAX_LEN-1:0] ALL_ONES = '1;
  localparam logic [MAX_LEN-1:0] ALL_ZERO = '0;

  logic [MAX_LEN-1:0] state_q;
  logic [MAX_LEN-1:0] state_d;
  logic [MAX_LEN-1:0] poly_q;
  logic [MAX_LEN-1:0] poly_d;
  logic [MAX_LEN-1:0] shift_res;
  logic [MAX_LEN-1:0] fb_mask;

  // One Galois step: the bit leaving at the bottom gates the tap mask, which
  // is XORed into the right-shifted state. Everything stays MAX_LEN wide.
  always_comb begin
    fb_mask   = state_q[0] ? poly_q : ALL_ZERO;
    shift_res = {1'b0, state_q[MAX_LEN-1:1]} ^ fb_mask;
  end

  // Load beats step; a zero seed or a zero state would lock the register at
  // zero forever, so both are redirected to all-ones.
  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    if (bus.LOAD_I) begin
      poly_d  = bus.POLY_I;
      state_d = (bus.SEED_I == ALL_ZERO) ? ALL_ONES : bus.SEED_I;
    end else if (bus.EN_I) begin
      state_d = (state_q == ALL_ZERO) ? ALL_ONES : shift_res;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ALL_ONES;
      poly_q  <= RST_POLY;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
    end
  end

  // Output is the register itself: no combinational path from any input.
  assign bus.DATA_O = state_q;

endmodule

// File: tb/tb_lfsr_galois.sv
// Purpose : self-checking bench for lfsr_galois (directed vectors plus random traffic).
// Latency : expects DATA_O to reflect each clock's strobes one clock later.
// Backpr. : n/a; one expected value is queued per driven clock.
module tb_lfsr_galois;
  localparam int W = 8;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  lfsr_galois_if #(.MAX_LEN(W)) bus ();

  lfsr_galois #(
    .MAX_LEN (W),
    .RST_POLY(8'hB8)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus  (bus)
  );

  // Scoreboard queues: expected DATA_O and a short name for each check.
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [W-1:0] m_state;
  logic [W-1:0] m_poly;

  // One step of the LFSR described arithmetically: halve, then XOR the taps
  // in when the value was odd; zero is replaced by all-ones.
  function automatic logic [W-1:0] model_step(input logic [W-1:0] s, input logic [W-1:0] p);
    int unsigned v;
    v = int'(s);
    if (v == 0) return 8'hFF;
    if (v % 2 == 1) return W'((v / 2) ^ int'(p));
    return W'(v / 2);
  endfunction

  // Drive one clock of stimulus, advance the model, and queue the expectation.
  // When use_k is set the queued value is the given constant instead of the
  // model output (used for hand-computed reference vectors).
  task automatic drive(input logic rst, input logic load, input logic en,
                       input logic [W-1:0] seed, input logic [W-1:0] poly,
                       input bit use_k, input logic [W-1:0] k, input string tag);
    @(negedge CLK_I);
    RST_I      = rst;
    bus.LOAD_I = load;
    bus.EN_I   = en;
    bus.SEED_I = seed;
    bus.POLY_I = poly;
    if (rst) begin
      m_state = 8'hFF;
      m_poly  = 8'hB8;
    end else if (load) begin
      m_state = (seed == 8'h00) ? 8'hFF : seed;
      m_poly  = poly;
    end else if (en) begin
      m_state = model_step(m_state, m_poly);
    end
    exp_q.push_back(use_k ? k : m_state);
    tag_q.push_back(tag);
  endtask

  // Monitor: one result per clock, sampled just after the rising edge.
  initial begin
    logic [W-1:0] e;
    string        t;
    forever begin
      @(posedge CLK_I);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (bus.DATA_O !== e) begin
          failures++;
          $display("FAIL %s: DATA_O=%02h expected %02h", t, bus.DATA_O, e);
        end
        // During the maximal-length run the state must never be 00 and must
        // not come back to the seed 01 before step 255.
        if (t == "period_run") begin
          checks++;
          if (bus.DATA_O == 8'h00 || bus.DATA_O == 8'h01) begin
            failures++;
            $display("FAIL period_early: DATA_O=%02h expected neither 00 nor 01", bus.DATA_O);
          end
        end
      end
    end
  end

  initial begin
    bus.EN_I   = 1'b0;
    bus.LOAD_I = 1'b0;
    bus.SEED_I = '0;
    bus.POLY_I = '0;

    // Reset overrides a simultaneous load and enable; first step after is C7.
    drive(1, 1, 1, 8'h3C, 8'h11, 1, 8'hFF, "rst_override");
    drive(0, 0, 1, 8'h00, 8'h00, 1, 8'hC7, "rst_first_step");

    // Load E7 with taps 99, then shift.
    drive(0, 1, 0, 8'hE7, 8'h99, 1, 8'hE7, "load_e7");
    drive(0, 0, 1, 8'h00, 8'h00, 1, 8'hEA, "shift1");
    drive(0, 0, 1, 8'h12, 8'h34, 1, 8'h75, "shift2");
    drive(0, 0, 1, 8'h56, 8'h78, 1, 8'hA3, "shift3");

    // Hold with garbage on SEED_I/POLY_I, then step with POLY_I=00.
    drive(0, 1, 0, 8'hE7, 8'h99, 1, 8'hE7, "reload_e7");
    repeat (10) drive(0, 0, 0, 8'($urandom), 8'($urandom), 1, 8'hE7, "hold");
    drive(0, 0, 1, 8'h00, 8'h00, 1, 8'hEA, "latched_poly");

    // Zero seed, and lockup recovery from a forced zero state.
    drive(0, 1, 0, 8'h00, 8'h99, 1, 8'hFF, "zero_seed");
    drive(0, 1, 0, 8'h01, 8'h00, 1, 8'h01, "load_01_p00");
    drive(0, 0, 1, 8'h00, 8'h00, 1, 8'h00, "to_zero");
    drive(0, 0, 1, 8'h00, 8'h00, 1, 8'hFF, "lockup_recover");

    // Maximal-length period with taps B8 from seed 01.
    drive(0, 1, 0, 8'h01, 8'hB8, 1, 8'h01, "period_load");
    for (int i = 1; i < 255; i++) drive(0, 0, 1, 8'($urandom), 8'($urandom), 0, 8'h00, "period_run");
    drive(0, 0, 1, 8'h00, 8'h00, 1, 8'h01, "period_255");

    // Load and enable together: load wins, no shift.
    drive(0, 1, 1, 8'h5A, 8'h8E, 1, 8'h5A, "load_en_collision");

    // Reset in the middle of a 50-step run, then resume from reset values.
    for (int i = 0; i < 50; i++) begin
      if (i == 25) drive(1, 0, 1, 8'h00, 8'h00, 1, 8'hFF, "rst_mid_run");
      else         drive(0, 0, 1, 8'($urandom), 8'($urandom), 0, 8'h00, "run50");
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic         r_rst, r_load, r_en;
      logic [W-1:0] r_seed;
      r_rst  = ($urandom_range(0, 39) == 0);
      r_load = ($urandom_range(0, 7) == 0);
      r_en   = 1'($urandom_range(0, 1));
      r_seed = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      drive(r_rst, r_load, r_en, r_seed, 8'($urandom), 0, 8'h00, "random");
    end

    // Quiesce and let the monitor drain, with a bound.
    drive(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, "final_hold");
    repeat (3) @(posedge CLK_I);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
